// File: rtl/conv_pkg.sv
// conv_pkg: shared limits and types for the conv line-buffer sequencer
package conv_pkg;
   localparam int PIXEL_W = 8;
   localparam int IMAGE_MAX_W = 16;
   localparam int IMAGE_MAX_H = 16;
   localparam int COL_W = $clog2(IMAGE_MAX_W);
   localparam int ROW_W = $clog2(IMAGE_MAX_H);
   localparam int WID_W = $clog2(IMAGE_MAX_W + 1);
   typedef enum logic [1:0] {IDLE, FIRST, RUN, FLUSH} sched_state_t;
   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      logic             top;
      logic             bottom;
      logic             left;
      logic             right;
   } win_meta_t;
   typedef struct packed {
      logic      vld;
      win_meta_t meta;
   } pipe_ent_t;
endpackage

// File: rtl/conv_lb_sched_pipe.sv
// conv_lb_sched_pipe: meta shift register matching the line-buffer push-to-output latency
module conv_lb_sched_pipe
   import conv_pkg::pipe_ent_t;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      en,
   input  pipe_ent_t din,
   output pipe_ent_t dout
);
   pipe_ent_t stage [DEPTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end
   assign dout = stage[DEPTH-1];
endmodule

// File: rtl/conv_lb_sched.sv
// conv_lb_sched: sequences pushes/pops into the line-buffer column, tracks raster
// position and emits column-aligned window strobes with border flags.
module conv_lb_sched
   import conv_pkg::PIXEL_W, conv_pkg::ROW_W, conv_pkg::COL_W, conv_pkg::WID_W,
          conv_pkg::sched_state_t, conv_pkg::win_meta_t, conv_pkg::pipe_ent_t,
          conv_pkg::IDLE, conv_pkg::FIRST, conv_pkg::RUN, conv_pkg::FLUSH;
#(
   parameter int KERNEL_H    = 3,
   parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W,
   parameter int IMAGE_MAX_H = conv_pkg::IMAGE_MAX_H,
   parameter int LB_LAT      = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_vld_i,
   output logic                s_rdy_o,
   input  logic [PIXEL_W-1:0]  s_dat_i,
   input  logic                s_sof_i,
   input  logic                s_eol_i,
   input  logic                s_eof_i,
   output logic [KERNEL_H-2:0] lb_push_o,
   output logic [KERNEL_H-2:0] lb_pop_o,
   output logic                lb_sof_o,
   output logic                lb_eol_o,
   output logic [PIXEL_W-1:0]  lb_dat_o,
   output logic                win_vld_o,
   input  logic                win_rdy_i,
   output win_meta_t           win_meta_o,
   output logic                err_o
);
   localparam int NB = KERNEL_H - 1;
   localparam int CNT_W = $clog2(LB_LAT + 1);
   sched_state_t     state, state_n;
   logic [ROW_W-1:0] row, cur_row;
   logic [COL_W-1:0] col, cur_col;
   logic [WID_W-1:0] width, col_nx;
   logic [CNT_W-1:0] fcnt;
   logic             acc, take, sof_acc, first, col_max, eol, eof, step, adv, mis;
   pipe_ent_t        pin, pout;
   assign s_rdy_o = ~rst & (state != FLUSH) & (~win_vld_o | win_rdy_i);
   assign acc     = s_vld_i & s_rdy_o;
   assign sof_acc = acc & s_sof_i;
   // a pixel is taken into the buffers unless it is dropped while hunting for sof
   assign take    = acc & ((state != IDLE) | s_sof_i);
   assign step    = ~rst & (state == FLUSH) & (~win_vld_o | win_rdy_i);
   assign adv     = acc | step;
   assign first   = sof_acc | (state == FIRST);
   assign cur_row = sof_acc ? '0 : row;
   assign cur_col = sof_acc ? '0 : col;
   assign col_nx  = WID_W'(cur_col) + WID_W'(1);
   assign col_max = cur_col == COL_W'(IMAGE_MAX_W - 1);
   assign eol     = take & (s_eol_i | col_max);
   assign eof     = eol & s_eol_i & s_eof_i;
   assign mis     = col_nx != width;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = (step & (fcnt == CNT_W'(LB_LAT - 1))) ? IDLE :
                eof ? FLUSH : (eol & first) ? RUN : sof_acc ? FIRST : state;
   end
   always_comb begin
      lb_push_o = '0;
      lb_pop_o  = '0;
      for (int k = 0; k < NB; k++) begin
         lb_push_o[k] = step | (take & (int'(cur_row) >= k));
         lb_pop_o[k]  = step | (take & (int'(cur_row) > k));
      end
      err_o = acc & (~take | (s_sof_i & (state != IDLE)) | (~s_eol_i & col_max) |
                     ((state == RUN) & ~s_sof_i & eol & mis));
   end
   assign lb_sof_o = sof_acc;
   assign lb_eol_o = eol;
   assign lb_dat_o = take ? s_dat_i : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         row   <= '0;
         col   <= '0;
         width <= '0;
         fcnt  <= '0;
      end else begin
         if (take) begin
            col <= eol ? '0 : cur_col + COL_W'(1);
            row <= (eol & (cur_row != ROW_W'(IMAGE_MAX_H - 1))) ? cur_row + ROW_W'(1) : cur_row;
            if (eol & first) width <= col_nx;
         end
         fcnt <= (state == FLUSH) ? fcnt + CNT_W'(step) : '0;
      end
   end
   always_comb begin
      pin             = '0;
      pin.vld         = take & (int'(cur_row) >= KERNEL_H - 1);
      pin.meta.row    = cur_row;
      pin.meta.col    = cur_col;
      pin.meta.top    = cur_row == ROW_W'(KERNEL_H - 1);
      pin.meta.bottom = s_eof_i;
      pin.meta.left   = cur_col == '0;
      pin.meta.right  = ~first & ~mis;
   end
   conv_lb_sched_pipe #(.DEPTH(LB_LAT)) u_pipe (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .din  (pin),
      .dout (pout)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         win_vld_o  <= 1'b0;
         win_meta_o <= '0;
      end else if (adv) begin
         win_vld_o  <= pout.vld;
         win_meta_o <= pout.meta;
      end else if (win_rdy_i) begin
         win_vld_o  <= 1'b0;
      end
   end
endmodule

// File: doc/conv_lb_sched.md
Name: conv_lb_sched

Overview:
- Sequencer in front of a column of KERNEL_H-1 chained line buffers in the conv datapath.
- Accepts a raster pixel stream over a valid/ready handshake.
- Generates per-buffer push/pop/sof/eol strobes, tracks row and column position, and measures line width on the first line.
- Emits a window-valid strobe with border flags, aligned to the buffers' column outputs, and flushes the buffer pipeline at end of frame.

Parameters:
- KERNEL_H, 3, kernel height; number of line buffers = KERNEL_H-1.
- IMAGE_MAX_W, conv_pkg::IMAGE_MAX_W, maximum line width in pixels.
- IMAGE_MAX_H, conv_pkg::IMAGE_MAX_H, maximum frame height in lines.
- LB_LAT, 2, push-to-column-output latency of a line buffer, in accepted pushes.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_vld_i  in  1  pixel valid.
- s_rdy_o  out  1  pixel ready.
- s_dat_i  in  PIXEL_W  pixel.
- s_sof_i  in  1  first pixel of frame.
- s_eol_i  in  1  last pixel of line.
- s_eof_i  in  1  last pixel of frame; qualified with s_eol_i.
- lb_push_o  out  KERNEL_H-1  per-buffer push.
- lb_pop_o  out  KERNEL_H-1  per-buffer pop.
- lb_sof_o  out  1  sof to all buffers.
- lb_eol_o  out  1  eol to all buffers.
- lb_dat_o  out  PIXEL_W  pixel to buffer 0; 0 during flush.
- win_vld_o  out  1  window column valid.
- win_rdy_i  in  1  window consumer ready.
- win_meta_o  out  conv_pkg::win_meta_t  row, col, top/bottom/left/right border flags.
- err_o  out  1  one-cycle error pulse.

Behaviour:
- Reset values: s_rdy_o=0, win_vld_o=0, err_o=0, all lb_* outputs 0.
- Internal reset values: state=IDLE, row=0, col=0, width=0, meta pipe valids=0.
- rst mid-frame discards all state; the line buffers are not cleared but are re-sequenced from the next sof.
- acc = s_vld_i & s_rdy_o.
- s_rdy_o = (state!=FLUSH) & (~win_vld_o | win_rdy_i). The buffers stall whenever push is low, so every lb strobe is gated by acc (or by flush step).
- FSM:
  - IDLE: drop pixels until acc & s_sof_i, then go to FIRST. A pixel without sof in IDLE is dropped and pulses err_o.
  - FIRST (row 0): lb_push_o[0]=acc; no pops. col increments per acc. On eol: width=col+1, row=1, go to RUN.
  - RUN: lb_push_o[k]=acc & (row>=k); lb_pop_o[k]=acc & (row>k). Pop always accompanies push.
    - On eol: if col+1!=width, pulse err_o and continue.
    - On eol: col=0, row++ (saturates at IMAGE_MAX_H-1).
    - On eol&eof: go to FLUSH.
  - FLUSH: issue LB_LAT steps, one per cycle while ~win_vld_o|win_rdy_i. Each step carries all pushes/pops with dat=0 and no eol. Then go to IDLE.
- sof during FIRST/RUN: pulse err_o, restart as FIRST, row=0, col=0.
- col saturates at IMAGE_MAX_W-1. Reaching IMAGE_MAX_W without eol forces an internal eol and pulses err_o.
- lb_sof_o = acc & s_sof_i; lb_eol_o = acc & s_eol_i.
- Meta pipe: LB_LAT-deep shift register, advanced on acc or flush step. Each entry holds {valid, meta}; valid = row>=KERNEL_H-1 at push time.
- Window output: win_vld_o and win_meta_o load from the pipe tail on advance. win_vld_o clears on win_rdy_i without advance.
- Window latency: exactly LB_LAT advances after the accept.
- Border flags:
  - top = row==KERNEL_H-1.
  - left = col==0.
  - right = col==width-1; 0 during FIRST.
  - bottom = eof line.
- Width rules: row and col use $clog2 of their max; comparisons are unsigned.

Decomposition:
- conv_pkg: win_meta_t (row, col, 4 border bits), IMAGE_MAX_H, sched_state_t enum.
- Sub-module conv_lb_sched_pipe: the LB_LAT meta shift register with enable.

Test Plan:
- 4x3 frame, win_rdy_i=1, no gaps -> push[0] on 12 cycles, pop[0] only on rows 1-2, push[1] on rows 1-2 only, win_vld_o 4 times (row 2, cols 0..3), left at col0, right at col3, bottom set, then 2 flush steps.
- Same frame with s_vld_i toggling every other cycle -> identical strobe counts and meta sequence; no strobe without acc.
- win_rdy_i=0 for 5 cycles mid-row -> s_rdy_o=0 in those cycles, no lb strobes, win_meta_o held stable.
- Row 1 eol at col 2 with width 4 -> err_o one pulse, row becomes 2, next line starts col=0.
- sof asserted at row 1 col 1 -> err_o pulse, state FIRST, push[0] only, no pops until next eol.
- rst asserted during FLUSH -> next cycle s_rdy_o=0, win_vld_o=0; new sof frame sequences from FIRST.
